// File: rtl/led_shift_driver.sv
// Serial output stage: shifts an N-bit LED word into a 74HC595-style register,
// generating SER / SRCLK / RCLK paced by a CLK_DIV system-clock divider.
module led_shift_driver #(
    parameter int N         = 8,
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] leds_in,
    input  logic         leds_valid,
    output logic         leds_ready,
    output logic         ser_data,
    output logic         ser_clk,
    output logic         ser_latch,
    output logic         busy
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          high_phase;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_next;
    logic          div_end;

    // The bit to put on SER always sits at the outgoing end of the shift register.
    function automatic logic out_bit(input logic [N-1:0] v);
        return MSB_FIRST ? v[N-1] : v[0];
    endfunction

    always_comb begin
        shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            high_phase <= 1'b0;
            shreg      <= '0;
            leds_ready <= 1'b1;
            busy       <= 1'b0;
            ser_data   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (leds_valid) begin
                        shreg      <= leds_in;
                        ser_data   <= out_bit(leds_in);
                        ser_clk    <= 1'b0;
                        high_phase <= 1'b0;
                        div_cnt    <= '0;
                        bit_cnt    <= '0;
                        leds_ready <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!high_phase) begin
                            high_phase <= 1'b1;
                            ser_clk    <= 1'b1;
                        end else begin
                            // End of a bit: SER only moves here, at the next low-phase start.
                            high_phase <= 1'b0;
                            ser_clk    <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                ser_data  <= 1'b0;
                                ser_latch <= 1'b1;
                                state     <= LATCH;
                            end else begin
                                bit_cnt  <= bit_cnt + BW'(1);
                                shreg    <= shreg_next;
                                ser_data <= out_bit(shreg_next);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + DW'(1);
                    end else begin
                        div_cnt    <= '0;
                        ser_latch  <= 1'b0;
                        leds_ready <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_driver.sv
// Bench for led_shift_driver: three configurations checked every cycle against a
// timing-formula model, plus directed checks of the received 595 words.
module tb_led_shift_driver;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0][7:0] din;
    logic [2:0]      valid, ready, sdata, sclk, slatch, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_shift_driver #(.N(8), .CLK_DIV(4), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .leds_in(din[0]), .leds_valid(valid[0]),
        .leds_ready(ready[0]), .ser_data(sdata[0]), .ser_clk(sclk[0]),
        .ser_latch(slatch[0]), .busy(busy[0]));

    led_shift_driver #(.N(8), .CLK_DIV(4), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .leds_in(din[1]), .leds_valid(valid[1]),
        .leds_ready(ready[1]), .ser_data(sdata[1]), .ser_clk(sclk[1]),
        .ser_latch(slatch[1]), .busy(busy[1]));

    led_shift_driver #(.N(4), .CLK_DIV(1), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .rst(rst), .leds_in(din[2][3:0]), .leds_valid(valid[2]),
        .leds_ready(ready[2]), .ser_data(sdata[2]), .ser_clk(sclk[2]),
        .ser_latch(slatch[2]), .busy(busy[2]));

    function automatic int pn(int i);
        return (i == 2) ? 4 : 8;
    endfunction
    function automatic int pd(int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic bit pm(int i);
        return (i != 1);
    endfunction

    // Model: m_t is the cycle index since capture edge E; transfer lasts 2ND+D cycles.
    bit          m_act  [3];
    int          m_t    [3];
    logic [31:0] m_word [3];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_act[i]  <= 1'b0;
                m_t[i]    <= 0;
                m_word[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!m_act[i]) begin
                    if (valid[i]) begin
                        m_act[i]  <= 1'b1;
                        m_t[i]    <= 1;
                        m_word[i] <= 32'(din[i]);
                    end
                end else if (m_t[i] == 2 * pn(i) * pd(i) + pd(i)) begin
                    m_act[i] <= 1'b0;
                    m_t[i]   <= 0;
                end else begin
                    m_t[i] <= m_t[i] + 1;
                end
            end
        end
    end

    // Expected {ready, busy, ser_clk, ser_data, ser_latch}.
    function automatic logic [4:0] exp_out(int i);
        int n = pn(i);
        int d = pd(i);
        int t = m_t[i];
        int b;
        logic [31:0] w = m_word[i];
        logic c, s;
        if (!m_act[i]) return 5'b10000;
        if (t <= 2 * n * d) begin
            b = (t - 1) / (2 * d);
            c = (((t - 1) % (2 * d)) >= d);
            s = pm(i) ? w[n - 1 - b] : w[b];
            return {1'b0, 1'b1, c, s, 1'b0};
        end
        return 5'b01001;
    endfunction

    function automatic logic [31:0] assemble(int i, logic [31:0] sr);
        int n = pn(i);
        if (pm(i)) return sr & ((32'd1 << n) - 32'd1);
        return sr >> (32 - n);
    endfunction

    // External 74HC595 receiver plus pulse-width monitors.
    int          cyc = 0;
    logic [2:0]  p_sclk = '0, p_slatch = '0;
    logic [31:0] rx_sr    [3] = '{0, 0, 0};
    logic        bit_log  [3][64];
    int          rise_cnt [3] = '{0, 0, 0};
    logic [31:0] lat_hist [3][16];
    int          lat_cyc  [3][16];
    int          lat_cnt  [3] = '{0, 0, 0};
    int          lat_run  [3] = '{0, 0, 0};
    int          lat_width[3] = '{0, 0, 0};
    int          rdy_run  [3] = '{0, 0, 0};
    int          rdy_low  [3] = '{0, 0, 0};

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        p_sclk   <= sclk;
        p_slatch <= slatch;
        for (int i = 0; i < 3; i++) begin
            if (sclk[i] && !p_sclk[i]) begin
                rx_sr[i] <= pm(i) ? {rx_sr[i][30:0], sdata[i]} : {sdata[i], rx_sr[i][31:1]};
                if (rise_cnt[i] < 64) bit_log[i][rise_cnt[i]] <= sdata[i];
                rise_cnt[i] <= rise_cnt[i] + 1;
            end
            if (slatch[i] && !p_slatch[i]) begin
                if (lat_cnt[i] < 16) begin
                    lat_hist[i][lat_cnt[i]] <= assemble(i, rx_sr[i]);
                    lat_cyc[i][lat_cnt[i]]  <= cyc;
                end
                lat_cnt[i] <= lat_cnt[i] + 1;
            end
            if (slatch[i]) lat_run[i] <= lat_run[i] + 1;
            else if (lat_run[i] != 0) begin
                lat_width[i] <= lat_run[i];
                lat_run[i]   <= 0;
            end
            if (!ready[i]) rdy_run[i] <= rdy_run[i] + 1;
            else if (rdy_run[i] != 0) begin
                rdy_low[i] <= rdy_run[i];
                rdy_run[i] <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++)
                check($sformatf("cycle%0d_dut%0d_outputs", cyc, i),
                      32'({ready[i], busy[i], sclk[i], sdata[i], slatch[i]}),
                      32'(exp_out(i)));
        end
    endtask

    initial begin
        int r0, l0;
        logic [7:0] exp_bits;
        logic [7:0] pat;

        rst   = 1'b0;
        din   = '0;
        valid = '1;
        step(4);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_outputs_dut%0d", i),
                  32'({ready[i], busy[i], sclk[i], sdata[i], slatch[i]}), 32'h10);
            check($sformatf("reset_no_sclk_dut%0d", i), 32'(rise_cnt[i]), 32'd0);
        end
        valid = '0;
        rst   = 1'b1;
        step(3);

        // Single word A5, MSB first
        r0 = rise_cnt[0]; l0 = lat_cnt[0];
        din[0] = 8'hA5; valid[0] = 1'b1;
        step(1);
        valid[0] = 1'b0;
        step(80);
        exp_bits = 8'b1010_0101;
        check("a5_rise_count", 32'(rise_cnt[0] - r0), 32'd8);
        for (int k = 0; k < 8; k++)
            check($sformatf("a5_bit%0d", k), 32'(bit_log[0][r0 + k]), 32'(exp_bits[7 - k]));
        check("a5_latch_count", 32'(lat_cnt[0] - l0), 32'd1);
        check("a5_latched", lat_hist[0][l0], 32'hA5);
        check("a5_latch_width", 32'(lat_width[0]), 32'd4);
        check("a5_ready_low", 32'(rdy_low[0]), 32'd68);

        // LSB first, word 01
        r0 = rise_cnt[1]; l0 = lat_cnt[1];
        din[1] = 8'h01; valid[1] = 1'b1;
        step(1);
        valid[1] = 1'b0;
        step(80);
        check("lsb_first_bit", 32'(bit_log[1][r0]), 32'd1);
        for (int k = 1; k < 8; k++)
            check($sformatf("lsb_bit%0d", k), 32'(bit_log[1][r0 + k]), 32'd0);
        check("lsb_latched", lat_hist[1][l0], 32'h01);
        check("lsb_ready_low", 32'(rdy_low[1]), 32'd68);

        // leds_in changes mid-transfer with valid held high
        l0 = lat_cnt[0];
        din[0] = 8'hF0; valid[0] = 1'b1;
        step(20);
        din[0] = 8'h0F;
        step(138);
        valid[0] = 1'b0;
        step(80);
        check("busy_latch_count", 32'(lat_cnt[0] - l0), 32'd3);
        check("busy_first", lat_hist[0][l0], 32'hF0);
        check("busy_second", lat_hist[0][l0 + 1], 32'h0F);
        check("busy_period", 32'(lat_cyc[0][l0 + 1] - lat_cyc[0][l0]), 32'd69);

        // Asynchronous reset in the middle of bit 3
        r0 = rise_cnt[0]; l0 = lat_cnt[0];
        din[0] = 8'hFF; valid[0] = 1'b1;
        step(1);
        valid[0] = 1'b0;
        step(26);
        check("abort_bits_before_reset", 32'(rise_cnt[0] - r0), 32'd3);
        #2 rst = 1'b0;
        #1 check("abort_async_outputs",
                 32'({ready[0], busy[0], sclk[0], sdata[0], slatch[0]}), 32'h10);
        step(3);
        rst = 1'b1;
        step(80);
        check("abort_no_latch", 32'(lat_cnt[0] - l0), 32'd0);
        din[0] = 8'h3C; valid[0] = 1'b1;
        step(1);
        valid[0] = 1'b0;
        step(80);
        check("after_reset_latch_count", 32'(lat_cnt[0] - l0), 32'd1);
        check("after_reset_latched", lat_hist[0][l0], 32'h3C);

        // N=4, CLK_DIV=1
        r0 = rise_cnt[2]; l0 = lat_cnt[2];
        din[2] = 8'h09; valid[2] = 1'b1;
        step(1);
        valid[2] = 1'b0;
        pat = {7'd0, sclk[2]};
        repeat (7) begin
            step(1);
            pat = {pat[6:0], sclk[2]};
        end
        step(20);
        check("div1_sclk_pattern", 32'(pat), 32'h55);
        check("div1_rise_count", 32'(rise_cnt[2] - r0), 32'd4);
        check("div1_ready_low", 32'(rdy_low[2]), 32'd9);
        check("div1_latch_width", 32'(lat_width[2]), 32'd1);
        check("div1_latched", lat_hist[2][l0], 32'h9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
